ft_pass_scheduler: RTL and testbench
====================================

// Module: ft_pass_scheduler
// PURPOSE
//  Multi-pass sequencer for the two-neuron fault-tolerant datapath. On a start
//  pulse it issues NPASS passes of the skewed row/column address stream. Each
//  pass is S+1 steps, with the column lagging the row by one step.
//  It stalls while row/col fault flags are raised and aborts to ERR on a
//  persistent fault. Sits between the top-level host handshake and the
//  row/column weight memories plus stage-2 enable.
// PARAMETERS
//  S          8   elements per pass; also the NULL address value
//  AW         3   address width - 1 (address buses are AW+1 bits, so S fits)
//  NPASS      4   passes per job
//  PW         2   width of pass index output
//  MAX_STALL  16  consecutive stall cycles that trigger ERR
//  SW         5   stall counter width (must hold MAX_STALL)
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     synchronous, active-high
//  start      in   1     job request pulse; accepted only in IDLE or ERR
//  abort      in   1     force return to IDLE
//  rfflag     in   1     row-side fault flag (stall, blocks stage 2)
//  cfflag     in   1     column-side fault flag (stall only)
//  addr_r     out  AW+1  row memory address, S = NULL
//  addr_c     out  AW+1  column memory address, S = NULL
//  en_s2      out  1     stage-2 enable (registered)
//  pass_idx   out  PW    current pass, 0..NPASS-1
//  busy       out  1     high in RUN
//  done       out  1     one-cycle pulse at job completion
//  err        out  1     sticky fault-timeout indicator
// BEHAVIOUR
//  - Reset: state=IDLE, k=0, pass_idx=0, stall_cnt=0, en_s2=0, busy=0,
//    done=0, err=0, addr_r=addr_c=S.
//  - States: IDLE, RUN, DONE, ERR. Step counter k spans 1..S+1 in RUN.
//  - Addresses are a combinational decode of the registered state and k.
//    RUN: addr_r = (k<=S) ? k-1 : S; addr_c = (k>=2) ? k-2 : S.
//    Any other state: both addresses = S.
//  - IDLE/ERR: start && !abort -> RUN, k=1, pass_idx=0, stall_cnt=0, err=0.
//    start && abort in the same cycle -> stay in the current state.
//  - RUN, advance condition: !rfflag && !cfflag.
//    - On advance: en_s2<=1, stall_cnt<=0.
//    - k<S+1: k<=k+1.
//    - k==S+1 and pass_idx<NPASS-1: pass_idx++, k<=1, with no gap cycle.
//    - k==S+1 and pass_idx==NPASS-1: go to DONE.
//  - RUN, stall (either flag high):
//    - k and pass_idx hold; en_s2<=!rfflag.
//    - cfflag-only stall keeps en_s2 at 1.
//    - stall_cnt++. If stall_cnt==MAX_STALL-1 on a stall -> ERR, en_s2<=0.
//  - DONE: done=1 for exactly one cycle, en_s2=0, busy=0; then IDLE.
//  - ERR: err=1 and held; en_s2=0; exit only via start or reset.
//  - abort in RUN or DONE: next state IDLE, k=0, pass_idx=0, en_s2=0, no done.
//  - Flags are ignored outside RUN. start in RUN or DONE is ignored.
//  - Latency, no stalls: start sampled at edge E0 -> RUN from E0.
//    done is high in the cycle after edge E0+NPASS*(S+1).
// TESTING
//  1 Defaults, start pulse, no flags.
//    -> per pass (addr_r,addr_c) = (0,8),(1,0),...,(7,6),(8,7).
//    -> pass_idx steps 0..3; done after 36 RUN cycles; en_s2=1 throughout.
//  2 rfflag high 3 cycles at k=4.
//    -> addresses frozen at (3,2); en_s2=0 for those 3 cycles.
//    -> done delayed by exactly 3 cycles.
//  3 cfflag high 2 cycles at k=6.
//    -> addresses frozen at (5,4); en_s2 stays 1; done delayed by 2.
//  4 rfflag held 16 cycles -> err=1, busy=0, addresses (8,8).
//    -> a new start clears err and restarts at pass 0, k=1.
//  5 abort during pass 2, k=5 -> IDLE next cycle, pass_idx=0, no done pulse.
//    -> reset mid-run gives the same result.
//  6 start while busy -> ignored, sequence unchanged.
//    -> start && abort together in IDLE -> remains IDLE.

Source files
------------

// File: rtl/ft_pass_scheduler.sv
// Multi-pass sequencer for the two-neuron fault-tolerant datapath: issues NPASS
// passes of the skewed row/column address stream, stalling on fault flags.
module ft_pass_scheduler #(
    parameter int S         = 8,
    parameter int AW        = 3,
    parameter int NPASS     = 4,
    parameter int PW        = 2,
    parameter int MAX_STALL = 16,
    parameter int SW        = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          rfflag,
    input  logic          cfflag,
    output logic [AW:0]   addr_r,
    output logic [AW:0]   addr_c,
    output logic          en_s2,
    output logic [PW-1:0] pass_idx,
    output logic          busy,
    output logic          done,
    output logic          err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    localparam int LK = S + 1;
    localparam int LP = NPASS - 1;
    localparam int MS = MAX_STALL - 1;
    localparam logic [AW:0]   NULL_A = S[AW:0];
    localparam logic [AW:0]   LAST_K = LK[AW:0];
    localparam logic [AW:0]   K_ZERO = '0;
    localparam logic [AW:0]   K_ONE  = 1;
    localparam logic [AW:0]   K_TWO  = 2;
    localparam logic [PW-1:0] LAST_P = LP[PW-1:0];
    localparam logic [PW-1:0] P_ONE  = 1;
    localparam logic [SW-1:0] LAST_S = MS[SW-1:0];
    localparam logic [SW-1:0] S_ONE  = 1;

    state_t        state;
    logic [AW:0]   k;
    logic [SW-1:0] stall_cnt;

    // Column trails the row by one step; the out-of-range ends read NULL.
    always_comb begin
        addr_r = NULL_A;
        addr_c = NULL_A;
        if (state == RUN) begin
            if (k <= NULL_A) addr_r = k - K_ONE;
            if (k >= K_TWO)  addr_c = k - K_TWO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k         <= K_ZERO;
            pass_idx  <= '0;
            stall_cnt <= '0;
            en_s2     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    if (start && !abort) begin
                        state     <= RUN;
                        k         <= K_ONE;
                        pass_idx  <= '0;
                        stall_cnt <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        en_s2     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        k         <= K_ZERO;
                        pass_idx  <= '0;
                        stall_cnt <= '0;
                        en_s2     <= 1'b0;
                        busy      <= 1'b0;
                    end else if (!rfflag && !cfflag) begin
                        stall_cnt <= '0;
                        en_s2     <= 1'b1;
                        if (k != LAST_K) begin
                            k <= k + K_ONE;
                        end else if (pass_idx != LAST_P) begin
                            pass_idx <= pass_idx + P_ONE;
                            k        <= K_ONE;
                        end else begin
                            state <= DONE;
                            k     <= K_ZERO;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            en_s2 <= 1'b0;
                        end
                    end else begin
                        // Only a row-side fault blocks stage 2.
                        en_s2     <= !rfflag;
                        stall_cnt <= stall_cnt + S_ONE;
                        if (stall_cnt == LAST_S) begin
                            state <= ERR;
                            k     <= K_ZERO;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            en_s2 <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    en_s2 <= 1'b0;
                    if (abort) begin
                        k        <= K_ZERO;
                        pass_idx <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ft_pass_scheduler.sv
// Scoreboard bench for ft_pass_scheduler: expected per-cycle outputs are queued
// as stimulus is driven and compared on the falling edge.
module tb_ft_pass_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       rfflag = 1'b0;
    logic       cfflag = 1'b0;
    logic [3:0] addr_r, addr_c;
    logic       en_s2;
    logic [1:0] pass_idx;
    logic       busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [13:0] e;
        logic [13:0] m;
    } ent_t;
    ent_t sb[$];

    localparam logic [13:0] ALL    = 14'h3FFF;
    localparam logic [13:0] NOPIDX = 14'h3FE7;

    ft_pass_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rfflag(rfflag), .cfflag(cfflag), .addr_r(addr_r), .addr_c(addr_c),
        .en_s2(en_s2), .pass_idx(pass_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got ar=%0d ac=%0d en=%0b p=%0d b=%0b d=%0b e=%0b, want ar=%0d ac=%0d en=%0b p=%0d b=%0b d=%0b e=%0b",
                     tag, obs[13:10], obs[9:6], obs[5], obs[4:3], obs[2], obs[1], obs[0],
                     exp[13:10], exp[9:6], exp[5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [13:0] o(input int ar, ac, input logic en, input int p,
                                      input logic b, d, e);
        return {4'(ar), 4'(ac), en, 2'(p), b, d, e};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            chk(x.tag, {addr_r, addr_c, en_s2, pass_idx, busy, done, err} & x.m, x.e & x.m);
        end
    end

    // Inputs set here are sampled at the next rising edge; e is this cycle's output.
    task automatic tick(input logic st, ab, rf, cf, rs, input logic [13:0] e, m, input string tag);
        @(posedge clk);
        #1;
        start = st; abort = ab; rfflag = rf; cfflag = cf; reset = rs;
        sb.push_back('{tag, e, m});
    endtask

    // One job from its first RUN cycle. Optional stall window, abort/reset point,
    // and a stray start pulse while busy.
    task automatic run_job(input string tag, input int sp, sk, slen, input logic srf, scf,
                           input int ap, ak, input logic use_rst, input int bp, bk);
        logic en;
        int ar, ac;
        en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            for (int k = 1; k <= 9; k++) begin
                ar = (k <= 8) ? k - 1 : 8;
                ac = (k >= 2) ? k - 2 : 8;
                if (p == sp && k == sk) begin
                    for (int j = 0; j < slen; j++) begin
                        tick(1'b0, 1'b0, srf, scf, 1'b0, o(ar, ac, en, p, 1'b1, 1'b0, 1'b0), ALL, {tag, "_stall"});
                        en = !srf;
                    end
                end
                if (p == ap && k == ak) begin
                    tick(1'b0, !use_rst, 1'b0, 1'b0, use_rst, o(ar, ac, en, p, 1'b1, 1'b0, 1'b0), ALL, {tag, "_run"});
                    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0), ALL, {tag, "_killed"});
                    return;
                end
                tick((p == bp && k == bk), 1'b0, 1'b0, 1'b0, 1'b0, o(ar, ac, en, p, 1'b1, 1'b0, 1'b0), ALL, {tag, "_run"});
                en = 1'b1;
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 3, 1'b0, 1'b1, 1'b0), ALL, {tag, "_done"});
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 3, 1'b0, 1'b0, 1'b0), NOPIDX, {tag, "_idle"});
    endtask

    task automatic go(input string tag);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0), NOPIDX, {tag, "_start"});
    endtask

    initial begin
        logic [13:0] idle0;
        idle0 = o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, idle0, ALL, "reset");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle0, ALL, "reset");
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, idle0, ALL, "idle");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, idle0, ALL, "idle_flags");

        go("plain");  run_job("plain", -1, 0, 0, 1'b0, 1'b0, -1, 0, 1'b0, -1, 0);
        go("rstall"); run_job("rstall", 1, 4, 3, 1'b1, 1'b0, -1, 0, 1'b0, -1, 0);
        go("cstall"); run_job("cstall", 2, 6, 2, 1'b0, 1'b1, -1, 0, 1'b0, -1, 0);
        go("stall15"); run_job("stall15", 3, 9, 15, 1'b1, 1'b0, -1, 0, 1'b0, -1, 0);

        // Persistent row fault: 16 consecutive stalls trip ERR.
        go("err");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o(0, 8, 1'b1, 0, 1'b1, 1'b0, 1'b0), ALL, "err_run");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o(1, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0), ALL, "err_run");
        for (int j = 0; j < 16; j++)
            tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, o(2, 1, (j == 0), 0, 1'b1, 1'b0, 1'b0), ALL, "err_stall");
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b1), ALL, "err_hold");
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b1), ALL, "err_hold");
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b1), ALL, "err_restart");
        run_job("after_err", -1, 0, 0, 1'b0, 1'b0, -1, 0, 1'b0, -1, 0);

        go("abort"); run_job("abort", -1, 0, 0, 1'b0, 1'b0, 2, 5, 1'b0, -1, 0);
        go("midrst"); run_job("midrst", -1, 0, 0, 1'b0, 1'b0, 1, 7, 1'b1, -1, 0);
        go("busystart"); run_job("busystart", -1, 0, 0, 1'b0, 1'b0, -1, 0, 1'b0, 1, 3);

        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0), NOPIDX, "startabort");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0), NOPIDX, "startabort_idle");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, o(8, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0), NOPIDX, "startabort_idle");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
